// File: rtl/tinytester_pkg.sv
// rtl/tinytester_pkg.sv - shared constants and FSM encoding for the tinytester vector sequencer
package tinytester_pkg;

  localparam logic [6:0] SEQ_IDLE    = 7'h20;
  localparam logic [6:0] SEQ_WAIT    = 7'h10;
  localparam int         VEC_DEPTH   = 8;
  localparam int         RES_DEPTH   = 8;
  localparam logic [7:0] TIMEOUT_MAX = 8'd255;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WAITSEQ,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/tt_sync_fifo.sv
// rtl/tt_sync_fifo.sv - single-clock first-word-fall-through FIFO with count/full/empty
module tt_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // a push into a full FIFO is still accepted when the head leaves in the same cycle
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/tinytester_vecseq.sv
// rtl/tinytester_vecseq.sv - feeds queued pad vectors to a tinytester and collects its results
module tinytester_vecseq
  import tinytester_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vec_wr_i,
  input  logic [31:0] vec_dout_i,
  input  logic [31:0] vec_oe_i,
  output logic        vec_full_o,
  output logic [3:0]  vec_count_o,
  input  logic        run_i,
  input  logic        clr_i,
  output logic [31:0] tt_control_o,
  output logic [31:0] tt_dataout_o,
  output logic [31:0] tt_oe_o,
  input  logic [6:0]  tt_seq_state_i,
  input  logic [31:0] tt_datain_i,
  input  logic        res_rd_i,
  output logic [31:0] res_data_o,
  output logic        res_empty_o,
  output logic        busy_o,
  output logic [1:0]  err_o
);

  state_t      state, state_nxt;
  logic [63:0] vec_head;
  logic        vec_empty;
  logic        vec_pop;
  logic        vec_drop;
  logic        res_full;
  logic [3:0]  res_count;
  logic        res_push;
  logic        start_q;
  logic [31:0] dout_q;
  logic [31:0] oe_q;
  logic [7:0]  to_cnt;
  logic [1:0]  err_q;
  logic        start_set, start_clr, to_clr, to_inc, to_err;

  tt_sync_fifo #(.WIDTH(64), .DEPTH(VEC_DEPTH)) u_vec_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vec_wr_i),
    .wr_data ({vec_oe_i, vec_dout_i}),
    .rd_en   (vec_pop),
    .rd_data (vec_head),
    .count   (vec_count_o),
    .full    (vec_full_o),
    .empty   (vec_empty)
  );

  tt_sync_fifo #(.WIDTH(32), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (res_push),
    .wr_data (tt_datain_i),
    .rd_en   (res_rd_i),
    .rd_data (res_data_o),
    .count   (res_count),
    .full    (res_full),
    .empty   (res_empty_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vec_pop   = 1'b0;
    res_push  = 1'b0;
    start_set = 1'b0;
    start_clr = 1'b0;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
    to_err    = 1'b0;
    case (state)
      S_IDLE: begin
        // only one vector is ever in flight, so a free result slot here guarantees room at capture
        if (run_i && !vec_empty && !res_full) begin
          state_nxt = S_ARM;
          vec_pop   = 1'b1;
        end
      end
      S_ARM: begin
        state_nxt = S_WAITSEQ;
        start_set = 1'b1;
        to_clr    = 1'b1;
      end
      S_WAITSEQ: begin
        if (tt_seq_state_i == SEQ_WAIT) begin
          state_nxt = S_DRAIN;
          res_push  = (res_count != 4'(RES_DEPTH));
          start_clr = 1'b1;
        end else if (to_cnt == TIMEOUT_MAX - 8'd1) begin
          state_nxt = S_DRAIN;
          start_clr = 1'b1;
          to_inc    = 1'b1;
          to_err    = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_DRAIN: begin
        if (tt_seq_state_i == SEQ_IDLE) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign vec_drop = vec_wr_i & vec_full_o & ~vec_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      dout_q  <= '0;
      oe_q    <= '0;
      to_cnt  <= '0;
      err_q   <= '0;
    end else begin
      if (vec_pop) {oe_q, dout_q} <= vec_head;
      if (start_set)      start_q <= 1'b1;
      else if (start_clr) start_q <= 1'b0;
      if (to_clr)         to_cnt <= '0;
      else if (to_inc)    to_cnt <= to_cnt + 8'd1;
      // a new error event in the clearing cycle survives the clear
      err_q <= (clr_i ? 2'b00 : err_q) | {to_err, vec_drop};
    end
  end

  assign tt_control_o = {31'b0, start_q};
  assign tt_dataout_o = dout_q;
  assign tt_oe_o      = oe_q;
  assign busy_o       = (state != S_IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_tinytester_vecseq.sv
// tb/tb_tinytester_vecseq.sv - self-checking bench with a behavioural tinytester model and scoreboard
module tb_tinytester_vecseq;
  import tinytester_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vec_wr_i;
  logic [31:0] vec_dout_i;
  logic [31:0] vec_oe_i;
  logic        vec_full_o;
  logic [3:0]  vec_count_o;
  logic        run_i;
  logic        clr_i;
  logic [31:0] tt_control_o;
  logic [31:0] tt_dataout_o;
  logic [31:0] tt_oe_o;
  logic [6:0]  tt_seq_state_i;
  logic [31:0] tt_datain_i;
  logic        res_rd_i;
  logic [31:0] res_data_o;
  logic        res_empty_o;
  logic        busy_o;
  logic [1:0]  err_o;

  tinytester_vecseq dut (
    .clk(clk), .rst_n(rst_n), .vec_wr_i(vec_wr_i), .vec_dout_i(vec_dout_i),
    .vec_oe_i(vec_oe_i), .vec_full_o(vec_full_o), .vec_count_o(vec_count_o),
    .run_i(run_i), .clr_i(clr_i), .tt_control_o(tt_control_o),
    .tt_dataout_o(tt_dataout_o), .tt_oe_o(tt_oe_o), .tt_seq_state_i(tt_seq_state_i),
    .tt_datain_i(tt_datain_i), .res_rd_i(res_rd_i), .res_data_o(res_data_o),
    .res_empty_o(res_empty_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // tinytester model knobs
  int lat_cfg    = 0;
  bit rand_lat   = 1'b0;
  bit never_wait = 1'b0;

  typedef struct {
    logic [31:0] dout;
    logic [31:0] oe;
    int          lat;
    logic [31:0] exp_res;
  } row_t;

  row_t        tbl [5];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] resp(input logic [31:0] d, input logic [31:0] o);
    return d ^ o ^ 32'h486E_0C22;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] o);
    vec_dout_i = d;
    vec_oe_i   = o;
    vec_wr_i   = 1'b1;
    tick;
    vec_wr_i   = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!tt_control_o[0] && n < 40) begin tick; n++; end
    chk(name, 64'(tt_control_o[0]), 64'd1);
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (res_empty_o && n < 60) begin tick; n++; end
    chk(name, 64'(res_empty_o), 64'd0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 400) begin tick; n++; end
    chk(name, 64'(busy_o), 64'd0);
  endtask

  // behavioural tinytester: busy for a latency, then reports SEQ_WAIT with its result
  initial begin
    bit active = 1'b0;
    int left = 0;
    tt_seq_state_i = SEQ_IDLE;
    tt_datain_i    = '0;
    forever begin
      tick;
      if (!tt_control_o[0]) begin
        tt_seq_state_i = SEQ_IDLE;
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          left = rand_lat ? int'($urandom_range(0, 6)) : lat_cfg;
        end
        if (never_wait) tt_seq_state_i = 7'h05;
        else if (left == 0) begin
          tt_seq_state_i = SEQ_WAIT;
          tt_datain_i    = resp(tt_dataout_o, tt_oe_o);
        end else begin
          tt_seq_state_i = 7'h05;
          left--;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    int pushed;
    logic [31:0] d, o;

    tbl[0] = '{32'hA5A5_A5A5, 32'hFFFF_FFFF, 0, 32'h1234_5678};
    tbl[1] = '{32'h0000_0000, 32'h0000_0000, 1, 32'h486E_0C22};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 3, 32'hB791_F3DD};
    tbl[3] = '{32'h1234_5678, 32'h0000_FFFF, 7, 32'h5A5A_A5A5};
    tbl[4] = '{32'hDEAD_BEEF, 32'hF0F0_F0F0, 2, 32'h6633_423D};

    rst_n = 1'b0; vec_wr_i = 1'b0; vec_dout_i = '0; vec_oe_i = '0;
    run_i = 1'b0; clr_i = 1'b0; res_rd_i = 1'b0;
    repeat (2) tick;
    chk("rst_control", 64'(tt_control_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_vec_count", 64'(vec_count_o), 64'd0);
    chk("rst_vec_full", 64'(vec_full_o), 64'd0);
    chk("rst_res_empty", 64'(res_empty_o), 64'd1);
    chk("rst_err", 64'(err_o), 64'd0);
    rst_n = 1'b1;
    tick;

    // single-vector transactions from the table
    run_i = 1'b1;
    foreach (tbl[i]) begin
      lat_cfg = tbl[i].lat;
      push(tbl[i].dout, tbl[i].oe);
      wait_start("tbl_start");
      chk("tbl_dataout", 64'(tt_dataout_o), 64'(tbl[i].dout));
      chk("tbl_oe", 64'(tt_oe_o), 64'(tbl[i].oe));
      wait_result("tbl_result_ready");
      chk("tbl_res_data", 64'(res_data_o), 64'(tbl[i].exp_res));
      res_rd_i = 1'b1;
      tick;
      res_rd_i = 1'b0;
      chk("tbl_res_empty_after_pop", 64'(res_empty_o), 64'd1);
      wait_idle("tbl_idle");
    end

    // overflow with run_i low, then clear
    run_i = 1'b0;
    for (int i = 0; i < 9; i++) push($urandom, $urandom);
    chk("ovf_count", 64'(vec_count_o), 64'd8);
    chk("ovf_full", 64'(vec_full_o), 64'd1);
    chk("ovf_err", 64'(err_o), 64'd1);
    clr_i = 1'b1;
    tick;
    clr_i = 1'b0;
    chk("ovf_err_cleared", 64'(err_o), 64'd0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    // tinytester never reaches SEQ_WAIT
    run_i = 1'b1;
    never_wait = 1'b1;
    push(32'h0F0F_0F0F, 32'h00FF_00FF);
    wait_start("to_start");
    hi = 0; n = 0;
    while (tt_control_o[0] && n < 400) begin hi++; n++; tick; end
    chk("to_start_high_cycles", 64'(hi), 64'd255);
    chk("to_err", 64'(err_o), 64'd2);
    chk("to_res_empty", 64'(res_empty_o), 64'd1);
    chk("to_dataout_held", 64'(tt_dataout_o), 64'h0F0F_0F0F);
    wait_idle("to_idle");
    never_wait = 1'b0;
    clr_i = 1'b1;
    tick;
    clr_i = 1'b0;
    chk("to_err_cleared", 64'(err_o), 64'd0);

    // result FIFO back-pressure: 10 vectors, no host reads
    run_i = 1'b0;
    lat_cfg = 2;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      d = $urandom; o = $urandom;
      push(d, o);
      exp_q.push_back(resp(d, o));
    end
    chk("bp_count8", 64'(vec_count_o), 64'd8);
    run_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n = 0;
      while (vec_full_o && n < 100) begin tick; n++; end
      d = $urandom; o = $urandom;
      push(d, o);
      exp_q.push_back(resp(d, o));
    end
    repeat (300) tick;
    chk("bp_vec_remaining", 64'(vec_count_o), 64'd2);
    chk("bp_idle", 64'(busy_o), 64'd0);
    chk("bp_no_err", 64'(err_o), 64'd0);
    chk("bp_first_res", 64'(res_data_o), 64'(exp_q[0]));
    void'(exp_q.pop_front());
    res_rd_i = 1'b1;
    tick;
    res_rd_i = 1'b0;
    n = 0;
    while (!busy_o && n < 10) begin tick; n++; end
    chk("bp_reissue", 64'(busy_o), 64'd1);
    chk("bp_vec_after_reissue", 64'(vec_count_o), 64'd1);
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      res_rd_i = 1'b0;
      if (!res_empty_o) begin
        chk("bp_drain_res", 64'(res_data_o), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        res_rd_i = 1'b1;
      end
      tick;
      n++;
    end
    res_rd_i = 1'b0;
    chk("bp_all_drained", 64'(exp_q.size()), 64'd0);
    wait_idle("bp_final_idle");

    // reset while waiting on the tinytester
    lat_cfg = 0;
    push(32'h1111_2222, 32'h3333_4444);
    wait_result("mr_prior_result");
    never_wait = 1'b1;
    for (int i = 0; i < 3; i++) push($urandom, $urandom);
    wait_start("mr_start");
    tick;
    chk("mr_pre_vec_count", 64'(vec_count_o), 64'd2);
    chk("mr_pre_res_empty", 64'(res_empty_o), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_control", 64'(tt_control_o), 64'd0);
    chk("mr_dataout", 64'(tt_dataout_o), 64'd0);
    chk("mr_oe", 64'(tt_oe_o), 64'd0);
    chk("mr_busy", 64'(busy_o), 64'd0);
    chk("mr_err", 64'(err_o), 64'd0);
    chk("mr_vec_count", 64'(vec_count_o), 64'd0);
    chk("mr_vec_full", 64'(vec_full_o), 64'd0);
    chk("mr_res_empty", 64'(res_empty_o), 64'd1);
    chk("mr_res_data", 64'(res_data_o), 64'd0);
    tick;
    never_wait = 1'b0;
    rst_n = 1'b1;
    tick;

    // randomized traffic against the scoreboard
    rand_lat = 1'b1;
    exp_q.delete();
    pushed = 0;
    for (int it = 0; it < 6000 && !(pushed == 60 && exp_q.size() == 0); it++) begin
      res_rd_i = 1'b0;
      vec_wr_i = 1'b0;
      if (!res_empty_o && $urandom_range(0, 2) == 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rnd_unexpected_result: got %h expected none", res_data_o);
        end else begin
          chk("rnd_res", 64'(res_data_o), 64'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        res_rd_i = 1'b1;
      end
      if (pushed < 60 && !vec_full_o && $urandom_range(0, 1) == 1) begin
        d = $urandom; o = $urandom;
        vec_dout_i = d;
        vec_oe_i   = o;
        vec_wr_i   = 1'b1;
        exp_q.push_back(resp(d, o));
        pushed++;
      end
      run_i = ($urandom_range(0, 7) != 0);
      tick;
    end
    res_rd_i = 1'b0;
    vec_wr_i = 1'b0;
    chk("rnd_all_pushed", 64'(pushed), 64'd60);
    chk("rnd_all_results", 64'(exp_q.size()), 64'd0);
    chk("rnd_vec_empty", 64'(vec_count_o), 64'd0);
    chk("rnd_no_err", 64'(err_o), 64'd0);
    chk("rnd_res_empty", 64'(res_empty_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tinytester_vecseq.md
TINYTESTER_VECSEQ -- requirements
Module: tinytester_vecseq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port vec_wr_i, input, 1 bit: host push of one test vector.
REQ-005 Port vec_dout_i, input, 32 bits: pad drive data for the pushed vector.
REQ-006 Port vec_oe_i, input, 32 bits: pad output-enable for the pushed vector.
REQ-007 Port vec_full_o, output, 1 bit: vector FIFO full.
REQ-008 Port vec_count_o, output, 4 bits: vector FIFO occupancy (0-8).
REQ-009 Port run_i, input, 1 bit: enable vector issue.
REQ-010 Port clr_i, input, 1 bit: synchronous clear of sticky flags.
REQ-011 Port tt_control_o, output, 32 bits: to tinytester control_i; bit0 is start; bits 31:1 are tied to 0.
REQ-012 Port tt_dataout_o, output, 32 bits: to tinytester dataout_i.
REQ-013 Port tt_oe_o, output, 32 bits: to tinytester oe_i.
REQ-014 Port tt_seq_state_i, input, 7 bits: from tinytester sequencer_state.
REQ-015 Port tt_datain_i, input, 32 bits: from tinytester datain_o.
REQ-016 Port res_rd_i, input, 1 bit: host pop of one result.
REQ-017 Port res_data_o, output, 32 bits: result FIFO head (first-word-fall-through).
REQ-018 Port res_empty_o, output, 1 bit: result FIFO empty.
REQ-019 Port busy_o, output, 1 bit: high whenever the FSM is not in S_IDLE.
REQ-020 Port err_o, output, 2 bits: sticky flags; bit0 = vector-FIFO overflow, bit1 = tinytester timeout.

Function
REQ-021 Vector FIFO SHALL be 8 deep x 64 bits {oe,dout}; result FIFO SHALL be 8 deep x 32 bits.
REQ-022 A push to a full FIFO SHALL be dropped; a dropped vector push SHALL set err_o[0].
REQ-023 A pop from an empty FIFO SHALL be ignored.
REQ-024 Simultaneous push and pop on a full or non-empty FIFO SHALL both take effect, with occupancy unchanged.
REQ-025 FSM states and transitions SHALL be:
- S_IDLE -> S_ARM when run_i=1, vector FIFO not empty, and result FIFO not full. On that edge the head vector is popped and registered onto tt_dataout_o/tt_oe_o.
- S_ARM -> S_WAITSEQ unconditionally. On that edge tt_control_o[0] is set to 1 and the timeout counter is cleared.
- S_WAITSEQ -> S_DRAIN when tt_seq_state_i==7'h10. On that edge tt_datain_i is pushed to the result FIFO and tt_control_o[0] is cleared.
- S_WAITSEQ -> S_DRAIN when the 8-bit timeout counter reaches 255 without 7'h10. On that edge err_o[1] is set, tt_control_o[0] is cleared, and nothing is pushed.
- S_DRAIN -> S_IDLE when tt_seq_state_i==7'h20.
REQ-026 tt_dataout_o and tt_oe_o SHALL hold stable from S_ARM until the next vector pop.
REQ-027 Minimum issue period SHALL be 4 cycles plus the tinytester latency; no vector SHALL be issued while the result FIFO is full.
REQ-028 Deasserting run_i mid-vector SHALL let the current vector complete; the FSM then stays in S_IDLE.
REQ-029 clr_i SHALL clear err_o; if clr_i and a set event occur in the same cycle, set SHALL win.
REQ-030 Result-FIFO push and res_rd_i in the same cycle SHALL both be honoured.

Reset
REQ-031 On rst_n=0, asynchronously: FSM = S_IDLE; both FIFOs empty; vec_count_o = 0; res_empty_o = 1; vec_full_o = 0.
REQ-032 On rst_n=0, asynchronously: tt_control_o, tt_dataout_o, tt_oe_o = 0; err_o = 0; busy_o = 0; timeout counter = 0.
REQ-033 Reset asserted mid-operation SHALL abandon the in-flight vector and drop tt_control_o[0] immediately.

Structure
REQ-034 Shared package tinytester_pkg SHALL hold: SEQ_IDLE=7'h20, SEQ_WAIT=7'h10, VEC_DEPTH=8, RES_DEPTH=8, TIMEOUT_MAX=255, and the FSM state enum.
REQ-035 One sub-module, tt_sync_fifo (parameters WIDTH, DEPTH; FWFT; count, full, and empty outputs), SHALL be instantiated twice.

Verification
REQ-036 Push {oe=FFFF_FFFF, dout=A5A5_A5A5}, run_i=1, tinytester model returning datain 1234_5678 -> tt_dataout_o=A5A5_A5A5, start pulse observed, res_data_o=1234_5678, res_empty_o=0.
REQ-037 Push 9 vectors with run_i=0 -> vec_count_o=8, vec_full_o=1, err_o=2'b01; after clr_i, err_o=0.
REQ-038 Model that never reaches 7'h10 -> tt_control_o[0] falls 255 cycles after arm, err_o[1]=1, res_empty_o stays 1.
REQ-039 Push 10 vectors, run_i=1, no res_rd_i -> exactly 8 results stored, 2 vectors remain, FSM idles; pop 1 result -> the next vector issues.
REQ-040 rst_n low during S_WAITSEQ -> all outputs 0 in the same cycle, FIFOs empty.
